// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared flit geometry, counter limits and dest-field helper for
//            the PE <-> H-tree fabric adapter.
// Revision : 1.0  initial release
// ============================================================================
package noc_pkg;

    localparam int c_DATA_WIDTH    = 34;
    localparam int c_ADDR_WIDTH    = 2;
    localparam int c_PAYLOAD_WIDTH = c_DATA_WIDTH - c_ADDR_WIDTH;

    localparam int               c_CNT_WIDTH = 8;
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_MAX = '1;

    // Destination field lives in the flit MSBs; the switches route on it.
    function automatic logic [c_ADDR_WIDTH-1:0] flit_dest(
        input logic [c_DATA_WIDTH-1:0] flit
    );
        return flit[c_DATA_WIDTH-1 -: c_ADDR_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : noc_sync_fifo
// Brief    : Synchronous FWFT FIFO with registered head, valid, ready and
//            level outputs; asynchronous active-high reset.
// Revision : 1.0  initial release
// ============================================================================
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_PW = $clog2(DEPTH);
    localparam logic [c_PW:0] c_DEPTH = (c_PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW:0]    r_wr_ptr;
    logic [c_PW:0]    r_rd_ptr;
    logic [c_PW:0]    r_level;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;
    logic             r_ready;

    logic             w_wr;
    logic             w_rd;
    logic [c_PW:0]    w_wr_ptr_nxt;
    logic [c_PW:0]    w_rd_ptr_nxt;
    logic [c_PW:0]    w_level_nxt;
    logic [c_PW:0]    w_level_after_rd;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_wr = wr_en & r_ready;
    assign w_rd = rd_en & r_valid;

    assign w_wr_ptr_nxt     = r_wr_ptr + (c_PW+1)'(w_wr);
    assign w_rd_ptr_nxt     = r_rd_ptr + (c_PW+1)'(w_rd);
    assign w_level_nxt      = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_level_after_rd = r_level - (c_PW+1)'(w_rd);

    // Next head: a write into an (effectively) empty FIFO bypasses storage,
    // otherwise the entry at the advanced read pointer is already in memory.
    always_comb begin
        w_head_nxt = '0;
        if (w_level_nxt != '0) begin
            if (w_wr && (w_level_after_rd == '0)) begin
                w_head_nxt = wr_data;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_nxt[c_PW-1:0]];
            end
        end
    end

    // Storage array; no reset needed since occupancy is tracked by pointers.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_PW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered status/head; ready stays low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_head   <= w_head_nxt;
            r_valid  <= (w_level_nxt != '0);
            r_ready  <= (w_level_nxt != c_DEPTH);
        end
    end

    assign wr_ready = r_ready;
    assign rd_data  = r_head;
    assign rd_valid = r_valid;
    assign level    = r_level;

endmodule
`default_nettype wire

// File: rtl/pe_noc_adapter.sv
`default_nettype none
// ============================================================================
// Module   : pe_noc_adapter
// Brief    : PE network interface: packs/queues outgoing flits, filters and
//            buffers incoming flits, counts self-sends and misroutes.
// Revision : 1.0  initial release
// ============================================================================
module pe_noc_adapter
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int MY_ADDR    = 0,
    parameter int TX_DEPTH   = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,
    input  logic [DATA_WIDTH-ADDR_WIDTH-1:0] i_pe_data,
    input  logic [ADDR_WIDTH-1:0]          i_pe_dest,
    input  logic                           i_pe_valid,
    output logic                           o_pe_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    output logic [DATA_WIDTH-ADDR_WIDTH-1:0] o_pe_rx_data,
    output logic                           o_pe_rx_valid,
    input  logic                           i_pe_rx_ready,
    output logic [$clog2(TX_DEPTH):0]      o_tx_level,
    output logic [c_CNT_WIDTH-1:0]         o_drop_count,
    output logic [c_CNT_WIDTH-1:0]         o_misroute_count
);

    localparam int                    c_PW   = DATA_WIDTH - ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_SELF = ADDR_WIDTH'(MY_ADDR);

    logic                   w_tx_ready;
    logic                   w_rx_ready;
    logic                   w_pe_fire;
    logic                   w_tx_wr;
    logic                   w_drop_inc;
    logic                   w_fab_fire;
    logic                   w_rx_wr;
    logic                   w_mis_inc;
    logic [1:0]             w_rx_level;
    logic [c_CNT_WIDTH-1:0] r_drop_count;
    logic [c_CNT_WIDTH-1:0] r_misroute_count;

    // Self-addressed sends are accepted but never reach the fabric.
    assign w_pe_fire  = i_pe_valid & w_tx_ready;
    assign w_tx_wr    = w_pe_fire & (i_pe_dest != c_SELF);
    assign w_drop_inc = w_pe_fire & (i_pe_dest == c_SELF);

    // Flits for another PE are consumed so they cannot block the fabric.
    assign w_fab_fire = i_data_valid & w_rx_ready;
    assign w_rx_wr    = w_fab_fire & (flit_dest(i_data) == c_SELF);
    assign w_mis_inc  = w_fab_fire & (flit_dest(i_data) != c_SELF);

    noc_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (i_sclk),
        .rst      (i_reset),
        .wr_en    (w_tx_wr),
        .wr_data  ({i_pe_dest, i_pe_data}),
        .wr_ready (w_tx_ready),
        .rd_en    (i_data_ready),
        .rd_data  (o_data),
        .rd_valid (o_data_valid),
        .level    (o_tx_level)
    );

    noc_sync_fifo #(
        .WIDTH (c_PW),
        .DEPTH (2)
    ) u_rx_fifo (
        .clk      (i_sclk),
        .rst      (i_reset),
        .wr_en    (w_rx_wr),
        .wr_data  (i_data[c_PW-1:0]),
        .wr_ready (w_rx_ready),
        .rd_en    (i_pe_rx_ready),
        .rd_data  (o_pe_rx_data),
        .rd_valid (o_pe_rx_valid),
        .level    (w_rx_level)
    );

    // Saturating event counters for discarded sends and misrouted flits.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            r_drop_count     <= '0;
            r_misroute_count <= '0;
        end else begin
            if (w_drop_inc && (r_drop_count != c_CNT_MAX)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
            if (w_mis_inc && (r_misroute_count != c_CNT_MAX)) begin
                r_misroute_count <= r_misroute_count + 1'b1;
            end
        end
    end

    assign o_pe_ready       = w_tx_ready;
    assign o_data_ready     = w_rx_ready;
    assign o_drop_count     = r_drop_count;
    assign o_misroute_count = r_misroute_count;

    // RX occupancy is not exported; fold it in so it is visibly consumed.
    logic w_unused;
    assign w_unused = ^w_rx_level;

endmodule
`default_nettype wire

// File: tb/tb_pe_noc_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_noc_adapter
// Brief    : Self-checking bench for pe_noc_adapter (MY_ADDR = 0, depth 4)
//            against a queue-based transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_noc_adapter;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pe_data;
    logic [1:0]  i_pe_dest;
    logic        i_pe_valid;
    logic        o_pe_ready;
    logic [33:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic [33:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [31:0] o_pe_rx_data;
    logic        o_pe_rx_valid;
    logic        i_pe_rx_ready;
    logic [2:0]  o_tx_level;
    logic [7:0]  o_drop_count;
    logic [7:0]  o_misroute_count;

    pe_noc_adapter dut (
        .i_sclk           (clk),
        .i_reset          (i_reset),
        .i_pe_data        (i_pe_data),
        .i_pe_dest        (i_pe_dest),
        .i_pe_valid       (i_pe_valid),
        .o_pe_ready       (o_pe_ready),
        .o_data           (o_data),
        .o_data_valid     (o_data_valid),
        .i_data_ready     (i_data_ready),
        .i_data           (i_data),
        .i_data_valid     (i_data_valid),
        .o_data_ready     (o_data_ready),
        .o_pe_rx_data     (o_pe_rx_data),
        .o_pe_rx_valid    (o_pe_rx_valid),
        .i_pe_rx_ready    (i_pe_rx_ready),
        .o_tx_level       (o_tx_level),
        .o_drop_count     (o_drop_count),
        .o_misroute_count (o_misroute_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction model: what the fabric/PE should see, in order.
    logic [33:0] txq[$];
    logic [31:0] rxq[$];
    int          m_drop = 0;
    int          m_mis  = 0;
    bit          m_hold = 1'b1;   // readies are low until the first edge after reset
    bit          last_pe_acc;
    bit          last_rx_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at the negedge, advance the model, then move
    // to just after the rising edge where the caller changes inputs.
    task automatic step();
        bit exp_pr, exp_dr;
        @(negedge clk);
        exp_pr = !m_hold && (txq.size() < 4);
        exp_dr = !m_hold && (rxq.size() < 2);
        check("pe_ready", 64'(o_pe_ready), 64'(exp_pr));
        check("tx_valid", 64'(o_data_valid), 64'(txq.size() > 0));
        if (txq.size() > 0) check("tx_data", 64'(o_data), 64'(txq[0]));
        check("tx_level", 64'(o_tx_level), 64'(txq.size()));
        check("drop_cnt", 64'(o_drop_count), 64'(m_drop));
        check("rx_ready", 64'(o_data_ready), 64'(exp_dr));
        check("rx_valid", 64'(o_pe_rx_valid), 64'(rxq.size() > 0));
        if (rxq.size() > 0) check("rx_data", 64'(o_pe_rx_data), 64'(rxq[0]));
        check("mis_cnt", 64'(o_misroute_count), 64'(m_mis));

        last_pe_acc = i_pe_valid && exp_pr;
        if (i_data_ready && txq.size() > 0) void'(txq.pop_front());
        if (last_pe_acc) begin
            if (i_pe_dest == 2'd0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else                   txq.push_back({i_pe_dest, i_pe_data});
        end
        last_rx_acc = i_data_valid && exp_dr;
        if (i_pe_rx_ready && rxq.size() > 0) void'(rxq.pop_front());
        if (last_rx_acc) begin
            if (i_data[33:32] == 2'd0) rxq.push_back(i_data[31:0]);
            else                       m_mis = (m_mis < 255) ? m_mis + 1 : 255;
        end
        m_hold = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        i_reset = 1'b1;
        i_pe_data = '0; i_pe_dest = '0; i_pe_valid = 1'b0;
        i_data_ready = 1'b0; i_data = '0; i_data_valid = 1'b0;
        i_pe_rx_ready = 1'b0;
        #2;
        check("rst_pe_ready", 64'(o_pe_ready), 64'd0);
        check("rst_rx_ready", 64'(o_data_ready), 64'd0);
        check("rst_tx_valid", 64'(o_data_valid), 64'd0);
        check("rst_tx_level", 64'(o_tx_level), 64'd0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        step();

        // 1. single send to dest 2
        i_data_ready = 1'b1;
        i_pe_valid = 1'b1; i_pe_dest = 2'd2; i_pe_data = 32'h1234_5678;
        step();
        i_pe_valid = 1'b0;
        check("t1_valid", 64'(o_data_valid), 64'd1);
        check("t1_flit", 64'(o_data), 64'h2_1234_5678);
        step();
        step();
        check("t1_level0", 64'(o_tx_level), 64'd0);

        // 2. fill TX with fabric stalled, then drain
        i_data_ready = 1'b0;
        i_pe_valid = 1'b1; i_pe_dest = 2'd1; i_pe_data = 32'h100;
        cnt = 0;
        for (int c = 0; c < 10 && cnt < 4; c++) begin
            step();
            if (last_pe_acc) begin cnt++; i_pe_data = 32'h100 + 32'(cnt); end
        end
        step(); step();
        check("t2_full_level", 64'(o_tx_level), 64'd4);
        check("t2_full_ready", 64'(o_pe_ready), 64'd0);
        i_data_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10 && cnt == 0; c++) begin
            step();
            if (last_pe_acc) cnt = 1;
        end
        check("t2_fifth_acc", 64'(cnt), 64'd1);
        i_pe_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();

        // 3. self-sends are counted, never forwarded, and saturate
        i_pe_valid = 1'b1; i_pe_dest = 2'd0; i_pe_data = 32'hDEAD;
        for (int c = 0; c < 3; c++) step();
        i_pe_valid = 1'b0;
        step();
        check("t3_drop3", 64'(o_drop_count), 64'd3);
        i_pe_valid = 1'b1;
        for (int c = 0; c < 260; c++) step();
        i_pe_valid = 1'b0;
        step();
        check("t3_drop_sat", 64'(o_drop_count), 64'd255);

        // 4. matching then misrouted flit back-to-back
        i_pe_rx_ready = 1'b1;
        i_data_valid = 1'b1; i_data = 34'h0_AAAA_0001;
        step();
        i_data = 34'h3_BBBB_0002;
        check("t4_rx_valid", 64'(o_pe_rx_valid), 64'd1);
        check("t4_rx_data", 64'(o_pe_rx_data), 64'hAAAA_0001);
        step();
        i_data_valid = 1'b0;
        step();
        check("t4_mis1", 64'(o_misroute_count), 64'd1);
        check("t4_no_present", 64'(o_pe_rx_valid), 64'd0);

        // 5. RX backpressure: two fit, third waits for a pop
        i_pe_rx_ready = 1'b0;
        i_data_valid = 1'b1; i_data = 34'h0_0000_0010;
        cnt = 0;
        for (int c = 0; c < 6 && cnt < 2; c++) begin
            step();
            if (last_rx_acc) begin cnt++; i_data = 34'h0_0000_0010 + 34'(cnt); end
        end
        step(); step();
        check("t5_rx_full", 64'(o_data_ready), 64'd0);
        i_pe_rx_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6 && cnt == 0; c++) begin
            step();
            if (last_rx_acc) cnt = 1;
        end
        check("t5_third_acc", 64'(cnt), 64'd1);
        i_data_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();

        // 6. asynchronous reset with TX flits queued
        i_data_ready = 1'b0;
        i_pe_valid = 1'b1; i_pe_dest = 2'd3; i_pe_data = 32'h5000;
        for (int c = 0; c < 3; c++) begin step(); i_pe_data = i_pe_data + 1; end
        i_pe_valid = 1'b0;
        #2 i_reset = 1'b1;
        #1;
        check("t6_valid0", 64'(o_data_valid), 64'd0);
        check("t6_level0", 64'(o_tx_level), 64'd0);
        check("t6_ready0", 64'(o_pe_ready), 64'd0);
        check("t6_drop0", 64'(o_drop_count), 64'd0);
        check("t6_mis0", 64'(o_misroute_count), 64'd0);
        check("t6_data0", 64'(o_data), 64'd0);
        txq.delete(); rxq.delete(); m_drop = 0; m_mis = 0; m_hold = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_data_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // 7. randomized traffic against the model
        last_pe_acc = 1'b0; last_rx_acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!i_pe_valid || last_pe_acc) begin
                i_pe_valid = ($urandom_range(0, 3) != 0);
                i_pe_dest  = 2'($urandom_range(0, 3));
                i_pe_data  = $urandom;
            end
            if (!i_data_valid || last_rx_acc) begin
                i_data_valid = ($urandom_range(0, 3) != 0);
                i_data = {($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom_range(1, 3)), 32'($urandom)};
            end
            i_data_ready  = ($urandom_range(0, 2) != 0);
            i_pe_rx_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
